// File: rtl/imm_extend_stage_if.sv
// Handshake bundle between decode and the immediate-extension stage.
// The stage uses the slave view; the producer/consumer side uses master.
interface imm_extend_stage_if #(
  parameter int IN_W  = 11,
  parameter int OUT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_err;

  modport master (
    output in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/imm_extend_stage.sv
// Registered immediate extension (zero / sign / high-place) behind a
// valid/ready main register plus one skid entry; strict FIFO order.
module imm_extend_stage #(
  parameter int IN_W  = 11,
  parameter int OUT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  imm_extend_stage_if.slave  bus
);

  localparam int SH = OUT_W - IN_W;

  logic [OUT_W-1:0] zeroExt;
  logic [OUT_W-1:0] signExt;
  logic [OUT_W-1:0] highExt;
  logic [OUT_W-1:0] extData;
  logic             extErr;

  logic [OUT_W-1:0] mainData_q, mainData_d;
  logic             mainErr_q, mainErr_d;
  logic             mainValid_q, mainValid_d;
  logic [OUT_W-1:0] skidData_q, skidData_d;
  logic             skidErr_q, skidErr_d;
  logic             skidValid_q, skidValid_d;
  logic             inReady_q;

  logic accept;
  logic consume;

  assign zeroExt = OUT_W'(bus.in_imm);
  assign signExt = OUT_W'($signed(bus.in_imm));
  assign highExt = zeroExt << SH;

  // Reserved mode behaves like zero-extend but flags the transfer.
  always_comb begin
    extData = zeroExt;
    extErr  = 1'b0;
    case (bus.in_mode)
      2'b00:   extData = zeroExt;
      2'b01:   extData = signExt;
      2'b10:   extData = highExt;
      default: extErr  = 1'b1;
    endcase
  end

  assign accept  = bus.in_valid & inReady_q;
  assign consume = mainValid_q & bus.out_ready;

  always_comb begin
    mainData_d  = mainData_q;
    mainErr_d   = mainErr_q;
    mainValid_d = mainValid_q;
    skidData_d  = skidData_q;
    skidErr_d   = skidErr_q;
    skidValid_d = skidValid_q;
    if (!mainValid_q || consume) begin
      if (skidValid_q) begin
        mainData_d  = skidData_q;
        mainErr_d   = skidErr_q;
        mainValid_d = 1'b1;
        skidValid_d = accept;
        if (accept) begin
          skidData_d = extData;
          skidErr_d  = extErr;
        end
      end else begin
        mainValid_d = accept;
        skidValid_d = 1'b0;
        if (accept) begin
          mainData_d = extData;
          mainErr_d  = extErr;
        end
      end
    end else if (accept) begin
      skidData_d  = extData;
      skidErr_d   = extErr;
      skidValid_d = 1'b1;
    end
  end

  // in_ready is registered so it never depends combinationally on out_ready;
  // it is held low through the reset cycle itself.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mainData_q  <= '0;
      mainErr_q   <= 1'b0;
      mainValid_q <= 1'b0;
      skidData_q  <= '0;
      skidErr_q   <= 1'b0;
      skidValid_q <= 1'b0;
      inReady_q   <= 1'b0;
    end else begin
      mainData_q  <= mainData_d;
      mainErr_q   <= mainErr_d;
      mainValid_q <= mainValid_d;
      skidData_q  <= skidData_d;
      skidErr_q   <= skidErr_d;
      skidValid_q <= skidValid_d;
      inReady_q   <= !skidValid_d;
    end
  end

  assign bus.in_ready  = inReady_q;
  assign bus.out_valid = mainValid_q;
  assign bus.out_data  = mainData_q;
  assign bus.out_err   = mainErr_q;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed self-checking bench for imm_extend_stage: modes, reserved flag,
// backpressure, streaming, mid-run reset and the IN_W = OUT_W corner.
module tb_imm_extend_stage;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  imm_extend_stage_if #(.IN_W(11), .OUT_W(16)) bus ();
  imm_extend_stage_if #(.IN_W(16), .OUT_W(16)) wbus ();

  imm_extend_stage #(.IN_W(11), .OUT_W(16)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  imm_extend_stage #(.IN_W(16), .OUT_W(16)) dutW (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (wbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%04h want 0x%04h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one transfer and returns #1 after the edge that accepted it.
  task automatic applyStimulus(input logic [10:0] imm, input logic [1:0] mode);
    bit done;
    done = 0;
    bus.in_valid = 1'b1;
    bus.in_imm   = imm;
    bus.in_mode  = mode;
    for (int c = 0; c < 10 && !done; c++) begin
      done = (bus.in_ready == 1'b1);
      tick();
    end
    bus.in_valid = 1'b0;
    if (!done) checkOutput("accept_timeout", 16'h0, 16'h1);
  endtask

  task automatic expectOut(input string tag, input logic [15:0] data, input logic err);
    checkOutput({tag, "_v"}, 16'(bus.out_valid), 16'h1);
    checkOutput({tag, "_d"}, bus.out_data, data);
    checkOutput({tag, "_e"}, 16'(bus.out_err), 16'(err));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_imm     = '0;
    bus.in_mode    = 2'b00;
    bus.out_ready  = 1'b1;
    wbus.in_valid  = 1'b0;
    wbus.in_imm    = '0;
    wbus.in_mode   = 2'b00;
    wbus.out_ready = 1'b1;

    tick();
    tick();
    checkOutput("rst_valid", 16'(bus.out_valid), 16'h0);
    checkOutput("rst_data", bus.out_data, 16'h0000);
    checkOutput("rst_err", 16'(bus.out_err), 16'h0);
    checkOutput("rst_ready", 16'(bus.in_ready), 16'h0);
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_ready", 16'(bus.in_ready), 16'h1);

    applyStimulus(11'h7FF, 2'b00); expectOut("zero_7ff", 16'h07FF, 1'b0);
    applyStimulus(11'h7FF, 2'b01); expectOut("sign_7ff", 16'hFFFF, 1'b0);
    applyStimulus(11'h400, 2'b01); expectOut("sign_400", 16'hFC00, 1'b0);
    applyStimulus(11'h3FF, 2'b01); expectOut("sign_3ff", 16'h03FF, 1'b0);
    applyStimulus(11'h001, 2'b10); expectOut("high_001", 16'h0020, 1'b0);
    applyStimulus(11'h7FF, 2'b11); expectOut("resv_7ff", 16'h07FF, 1'b1);
    applyStimulus(11'h001, 2'b00); expectOut("after_resv", 16'h0001, 1'b0);
    tick();
    checkOutput("drain_valid", 16'(bus.out_valid), 16'h0);

    // Backpressure: A and B fill main and skid, C waits.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_mode   = 2'b00;
    bus.in_imm    = 11'h001;
    checkOutput("bp_ready_a", 16'(bus.in_ready), 16'h1);
    tick();
    expectOut("bp_main_a", 16'h0001, 1'b0);
    bus.in_imm = 11'h002;
    checkOutput("bp_ready_b", 16'(bus.in_ready), 16'h1);
    tick();
    checkOutput("bp_ready_low", 16'(bus.in_ready), 16'h0);
    bus.in_imm = 11'h003;
    tick();
    checkOutput("bp_ready_held", 16'(bus.in_ready), 16'h0);
    expectOut("bp_hold_a", 16'h0001, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    expectOut("bp_out_b", 16'h0002, 1'b0);
    checkOutput("bp_ready_back", 16'(bus.in_ready), 16'h1);
    tick();
    bus.in_valid = 1'b0;
    expectOut("bp_out_c", 16'h0003, 1'b0);
    tick();
    checkOutput("bp_empty", 16'(bus.out_valid), 16'h0);

    // Streaming: one result per cycle with no bubbles.
    bus.in_valid = 1'b1;
    bus.in_mode  = 2'b01;
    for (int i = 0; i < 8; i++) begin
      bus.in_imm = 11'(i);
      tick();
      expectOut($sformatf("stream_%0d", i), 16'(i), 1'b0);
    end
    bus.in_valid = 1'b0;
    tick();
    checkOutput("stream_end", 16'(bus.out_valid), 16'h0);

    // Mid-run reset with both entries occupied.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_mode   = 2'b11;
    bus.in_imm    = 11'h155;
    tick();
    tick();
    bus.in_valid = 1'b0;
    checkOutput("mr_full", 16'(bus.in_ready), 16'h0);
    rst_n = 1'b0;
    tick();
    checkOutput("mr_valid", 16'(bus.out_valid), 16'h0);
    checkOutput("mr_data", bus.out_data, 16'h0000);
    checkOutput("mr_err", 16'(bus.out_err), 16'h0);
    checkOutput("mr_ready", 16'(bus.in_ready), 16'h0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    checkOutput("mr_ready_back", 16'(bus.in_ready), 16'h1);
    checkOutput("mr_no_stale0", 16'(bus.out_valid), 16'h0);
    tick();
    checkOutput("mr_no_stale1", 16'(bus.out_valid), 16'h0);

    // IN_W = OUT_W: every mode is a passthrough.
    wbus.in_valid = 1'b1;
    wbus.in_imm   = 16'h8001;
    for (int m = 0; m < 3; m++) begin
      wbus.in_mode = 2'(m);
      checkOutput($sformatf("wide_ready_%0d", m), 16'(wbus.in_ready), 16'h1);
      tick();
      checkOutput($sformatf("wide_valid_%0d", m), 16'(wbus.out_valid), 16'h1);
      checkOutput($sformatf("wide_data_%0d", m), wbus.out_data, 16'h8001);
      checkOutput($sformatf("wide_err_%0d", m), 16'(wbus.out_err), 16'h0);
    end
    wbus.in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
